// File: rtl/mult_pkg.sv
// Shared types and sizes for the shift/add multiplier controller.
package mult_pkg;

    localparam int WIDTH  = 16;   // operand width, tied to the shifter
    localparam int PWIDTH = 32;   // product width
    localparam int SWIDTH = 5;    // step counter width, holds 0..16

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/barrel_shift_16bit.sv
// 16-bit logarithmic barrel shifter: left shift with zero fill.
module barrel_shift_16bit (
    input  logic [15:0] in,
    input  logic [3:0]  ctrl,
    output logic [15:0] out
);

    logic [15:0] s0, s1, s2;

    // Four binary-weighted stages, one per ctrl bit.
    always_comb begin
        s0  = ctrl[0] ? {in[14:0], 1'b0} : in;
        s1  = ctrl[1] ? {s0[13:0], 2'b0} : s0;
        s2  = ctrl[2] ? {s1[11:0], 4'b0} : s1;
        out = ctrl[3] ? {s2[7:0],  8'b0} : s2;
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 16x16 unsigned multiplier: one shift/add step per set bit of b.
//
// Handshake: a transfer happens on the rising edge where valid && ready are
// both high. in_ready depends only on state (high in IDLE); once out_valid
// rises in DONE, product and steps hold until out_ready takes them.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      product,
    output logic [4:0]       steps,
    output logic [1:0]       dbg_state
);

    import mult_pkg::*;

    state_t              state;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic [PWIDTH-1:0]   acc;
    logic [SWIDTH-1:0]   steps_r;

    logic [3:0]          k;
    logic [WIDTH-1:0]    lo;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    b_next;
    logic [PWIDTH-1:0]   sum;

    // Priority encoder: index of the lowest set bit of b_r (0 when b_r is 0).
    always_comb begin
        k = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (b_r[i]) k = 4'(i);
        end
    end

    barrel_shift_16bit u_shift (
        .in   (a_r),
        .ctrl (k),
        .out  (lo)
    );

    // Bits shifted out of the low half form the high half of the partial product.
    always_comb begin
        hi     = (k == 4'd0) ? '0 : (a_r >> (5'd16 - {1'b0, k}));
        b_next = b_r & ~(16'd1 << k);
        sum    = acc + {hi, lo};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            steps_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        acc     <= '0;
                        steps_r <= '0;
                        state   <= (a == '0 || b == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    acc     <= sum;
                    b_r     <= b_next;
                    steps_r <= steps_r + 5'd1;
                    if (b_next == '0) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = acc;
    assign steps     = steps_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: directed cases plus a
// throttled random regression against an a*b / popcount reference.
module tb_shift_add_mult_ctrl;

    localparam int W = 37;   // {steps[4:0], product[31:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic [4:0]  steps;
    logic [1:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           or_mode = 1;   // 0: out_ready low, 1: high, 2: random

    shift_add_mult_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .steps     (steps),
        .dbg_state (dbg_state)
    );

    // Clock and out_ready throttling.
    always #5 clk = ~clk;

    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [15:0] ma, input logic [15:0] mb);
        logic [31:0] p;
        logic [4:0]  s;
        p = 32'(ma) * 32'(mb);
        s = (ma == 16'd0) ? 5'd0 : 5'($countones(mb));
        return {s, p};
    endfunction

    // Scoreboard: compare each delivered product against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_output", 64'(out_valid), 64'd0);
            end else begin
                check("result", 64'({steps, product}), 64'(exp_q.pop_front()));
            end
        end
    end

    // Drive one operand pair, hold until accepted; returns just after the accept edge.
    task automatic send(input logic [15:0] sa, input logic [15:0] sb, input int gap);
        bit ok;
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = sa;
        b = sb;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(sa, sb));
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count clock edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat, output int busy_ready);
        lat = 0;
        busy_ready = 0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready) busy_ready++;
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic directed(input string tag, input logic [15:0] da, input logic [15:0] db,
                            input int exp_lat);
        int lat, br;
        send(da, db, 0);
        wait_done(lat, br);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_in_ready_busy"}, 64'(br), 64'd0);
    endtask

    initial begin
        int  lat, br, seen;
        logic [15:0] ra, rb;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product",   64'(product),   64'd0);
        check("rst_steps",     64'(steps),     64'd0);
        check("rst_state",     64'(dbg_state), 64'd0);

        // Directed: edges after accept = popcount(b), or 0 when an operand is zero
        directed("two_bits",  16'h4001, 16'h0003, 2);
        directed("full",      16'hFFFF, 16'hFFFF, 16);
        directed("b_zero",    16'h1234, 16'h0000, 0);
        directed("a_zero",    16'h0000, 16'hFFFF, 0);
        directed("one_bit",   16'h0001, 16'h0400, 1);

        // Back-pressure on the k=15 path; new operands offered during the stall
        or_mode = 0;
        send(16'h8000, 16'h8000, 1);
        wait_done(lat, br);
        check("bp_latency", 64'(lat), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 16'h0005;
        b = 16'h0007;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_product",   64'(product),   64'h4000_0000);
            check("bp_steps",     64'(steps),     64'd1);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        or_mode = 1;
        repeat (4) @(posedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of RUN
        send(16'h00FF, 16'hFF00, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_state",    64'(dbg_state), 64'd0);
        check("abort_in_ready", 64'(in_ready),  64'd1);
        check("abort_product",  64'(product),   64'd0);
        check("abort_steps",    64'(steps),     64'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_output", 64'(seen), 64'd0);

        // Random regression with throttling on both sides
        or_mode = 2;
        for (int n = 0; n < 3000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 9))
                0: ra = '0;
                1: rb = '0;
                2: rb = 16'hFFFF;
                3: ra = 16'hFFFF;
                default: ;
            endcase
            send(ra, rb, $urandom_range(0, 2));
        end
        or_mode = 1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
